// File: rtl/halton_seq_gen.sv
// halton_seq_gen: radix-inverse (Halton / van der Corput) point generator.
// The sequence index is held as DIGITS cascaded mod-BASE digit counters. Each
// enabled cycle emits the digit-reversed index, scaled to 0..BASE**DIGITS-1.
// Optional build macro: HALTON_SCRAMBLE_EN rotates digit i by (i+1) mod BASE
// before reversal, which gives a fixed-rotation scrambled sequence.
module halton_seq_gen #(
  parameter int BASE   = 5,
  parameter int DIGITS = 3,
  localparam int     LOGBASE  = $clog2(BASE),
  localparam longint PERIOD   = longint'(BASE) ** DIGITS,
  localparam int     SEQWIDTH = $clog2(PERIOD)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        clr,
  input  logic                        load,
  input  logic [DIGITS*LOGBASE-1:0]   load_digits,
  output logic [SEQWIDTH-1:0]         out,
  output logic                        valid,
  output logic                        wrap
);

  localparam logic [LOGBASE-1:0] DMAX = LOGBASE'(BASE - 1);

  logic [DIGITS-1:0][LOGBASE-1:0]  dig_q;
  logic [DIGITS-1:0][LOGBASE-1:0]  dig_d;
  logic [DIGITS-1:0][LOGBASE-1:0]  eff_s;
  logic [DIGITS-1:0][SEQWIDTH-1:0] term_s;
  logic [SEQWIDTH-1:0]             rev_s;
  logic [SEQWIDTH-1:0]             out_q;
  logic [SEQWIDTH-1:0]             out_d;
  logic                            valid_q;
  logic                            valid_d;
  logic                            wrap_q;
  logic                            wrap_d;
  logic                            at_max_s;
  logic                            carry_s;

  // A loaded digit outside 0..BASE-1 saturates to the largest legal digit.
  function automatic logic [LOGBASE-1:0] clamp_digit(input logic [LOGBASE-1:0] raw);
    if ({1'b0, raw} >= (LOGBASE+1)'(BASE)) begin
      return DMAX;
    end else begin
      return raw;
    end
  endfunction

  // Per-digit effective value and its constant-weighted contribution.
  // Digit i lands at weight BASE**(DIGITS-1-i): that is the radix reversal.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    localparam logic [SEQWIDTH-1:0] WEIGHT = SEQWIDTH'(longint'(BASE) ** (DIGITS - 1 - g));
`ifdef HALTON_SCRAMBLE_EN
    // Both operands are below BASE, so one conditional subtract replaces mod.
    localparam logic [LOGBASE:0] ROT = (LOGBASE+1)'((g + 1) % BASE);
    logic [LOGBASE:0] rot_sum_s;
    assign rot_sum_s = {1'b0, dig_q[g]} + ROT;
    assign eff_s[g]  = (rot_sum_s >= (LOGBASE+1)'(BASE))
                       ? LOGBASE'(rot_sum_s - (LOGBASE+1)'(BASE))
                       : rot_sum_s[LOGBASE-1:0];
`else
    assign eff_s[g] = dig_q[g];
`endif
    assign term_s[g] = SEQWIDTH'(eff_s[g]) * WEIGHT;
  end

  // Sum the weighted digits; the total is at most P-1, so it fits SEQWIDTH.
  always_comb begin
    rev_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      rev_s = rev_s + term_s[i];
    end
  end

  // Index is at P-1 when every digit sits at BASE-1.
  always_comb begin
    at_max_s = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      at_max_s = at_max_s & (dig_q[i] == DMAX);
    end
  end

  // Next-state: clr beats load beats en; the digit carry chain ripples from digit 0.
  always_comb begin
    dig_d   = dig_q;
    out_d   = out_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    carry_s = 1'b0;
    if (clr) begin
      dig_d = '0;
    end else if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        dig_d[i] = clamp_digit(load_digits[i*LOGBASE +: LOGBASE]);
      end
    end else if (en) begin
      out_d   = rev_s;
      valid_d = 1'b1;
      wrap_d  = at_max_s;
      carry_s = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        if (carry_s) begin
          if (dig_q[i] == DMAX) begin
            dig_d[i] = '0;
          end else begin
            dig_d[i] = dig_q[i] + LOGBASE'(1);
            carry_s  = 1'b0;
          end
        end else begin
          dig_d[i] = dig_q[i];
        end
      end
    end else begin
      dig_d = dig_q;
    end
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      dig_q   <= dig_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: doc/halton_seq_gen.md
HALTON_SEQ_GEN -- requirements
Module: halton_seq_gen

Interface
REQ-001 Parameter BASE, default 5: radix of the sequence; legal 2..16.
REQ-002 Parameter DIGITS, default 3: number of base-BASE digits; legal 1..8; period P = BASE^DIGITS.
REQ-003 Derived localparam LOGBASE = ceil(log2(BASE)), the width of one digit.
REQ-004 Derived localparam SEQWIDTH = ceil(log2(P)), the output width; P <= 2^32.
REQ-005 clk  input  1  sole clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 en  input  1  advance request; one sequence point per enabled cycle.
REQ-008 clr  input  1  synchronous restart of the index to 0.
REQ-009 load  input  1  synchronous load of the index digits from load_digits.
REQ-010 load_digits  input  DIGITS*LOGBASE  index digits, digit 0 (least significant) in the lowest LOGBASE bits.
REQ-011 out  output  SEQWIDTH  registered Halton point, integer-scaled to 0..P-1.
REQ-012 valid  output  1  registered; high when out holds a point emitted this cycle.
REQ-013 wrap  output  1  registered; high with the point for index P-1.

Function
REQ-014 The index is held as DIGITS cascaded mod-BASE digit counters; digit 0 carry-in = en, and digit i carry-in = carry-out of digit i-1.
REQ-015 Each digit counts 0..BASE-1, wraps to 0 and asserts carry-out only when it is at BASE-1 with carry-in high.
REQ-016 Index P-1 advances to 0 (full wrap), and no sticky state results.
REQ-017 On an en cycle: out <= sum over i of d_i * BASE^(DIGITS-1-i), i.e. the radix-reversed current index; the index then increments.
REQ-018 Latency: out reflects the index sampled at the same edge, so valid and out rise 1 cycle after en is sampled high.
REQ-019 valid <= en; when en is low, out holds its last value and valid = 0.
REQ-020 wrap <= en AND (index == P-1); otherwise wrap = 0.
REQ-021 Priority: clr > load > en; clr sets all digits to 0; load sets the digits to load_digits; on either, valid and wrap are 0 and out holds its value.
REQ-022 A loaded digit >= BASE is clamped to BASE-1.
REQ-023 Reversal arithmetic uses constant multipliers only; no dividers; the result is exact within SEQWIDTH.

Reset
REQ-024 When rst is high, all digits, out, valid and wrap are 0 immediately, independent of clk.
REQ-025 Reset asserted mid-sequence discards the index; the first en after release emits out = 0.

Configuration
REQ-026 With macro HALTON_SCRAMBLE_EN defined, each digit is replaced by (d_i + i + 1) mod BASE before reversal, giving a fixed-rotation scrambled Halton sequence.
REQ-027 Without HALTON_SCRAMBLE_EN, digits are reversed unmodified; the counting, wrap and valid behaviour are identical in both builds.

Verification (BASE=5, DIGITS=3, P=125 unless noted)
REQ-028 Release rst, en=1 continuously -> out on successive valid cycles: 0,25,50,75,100,5,30,55.
REQ-029 en=1 for 125 cycles -> wrap high only with the 125th point (out=124), then out=0 next; all 125 values are distinct.
REQ-030 en toggled 1,0,0,1 -> valid 1,0,0,1 (delayed by 1 cycle); out holds during the gaps; no index skipped.
REQ-031 load with digits {d2,d1,d0}={1,2,3} and en=1 the next cycle -> out=3*25+2*5+1=86; load digit 7 -> treated as 4; clr and load together -> index 0.
REQ-032 HALTON_SCRAMBLE_EN defined, reset then en -> first out=38 (digits 0,0,0 map to 1,2,3).
REQ-033 rst pulsed asynchronously between edges mid-run -> out/valid/wrap go to 0 at once; the next en emits 0; repeat for BASE=2, DIGITS=8 (out 0,128,64,192).
